// File: rtl/axis_event_packetizer.sv
// Frames a stream of event words into AXI-Stream packets with tlast.
// Define AXIS_PKT_TIMEOUT_EN to close open packets after an input idle timeout.
module axis_event_packetizer #(
    parameter int AXIS_BUS_WIDTH = 64,
    parameter int PACKET_LEN     = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      m_axi_aclk,
    input  logic                      m_axi_aresetn,
    input  logic [AXIS_BUS_WIDTH-1:0] ev_data,
    input  logic                      ev_valid,
    output logic                      ev_ready,
    input  logic                      flush,
    output logic [AXIS_BUS_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready,
    output logic                      busy
);

    localparam int CW = $clog2(PACKET_LEN);

    typedef enum logic {
        EMPTY,
        HOLD
    } state_t;

    state_t                    state;
    logic [AXIS_BUS_WIDTH-1:0] pend_data;
    logic [CW-1:0]             word_cnt;
    logic                      flush_req;
    logic                      pend_valid;
    logic                      out_free;
    logic                      ev_fire;
    logic                      timeout_hit;
    logic                      close;
    logic                      launch;

    assign pend_valid = (state == HOLD);
    assign out_free   = !m_axis_tvalid | m_axis_tready;
    assign ev_ready   = !pend_valid | out_free;
    assign ev_fire    = ev_valid & ev_ready;
    assign close      = (word_cnt == CW'(PACKET_LEN - 1)) | timeout_hit
                      | flush_req | flush;
    assign launch     = pend_valid & out_free & (ev_fire | close);
    assign busy       = pend_valid | m_axis_tvalid;

`ifdef AXIS_PKT_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES);

    logic [IW-1:0] idle_cnt;

    assign timeout_hit = pend_valid
                       & (idle_cnt >= IW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            idle_cnt <= '0;
        end else if (ev_fire | (launch & close)) begin
            idle_cnt <= '0;
        end else if (pend_valid && idle_cnt < IW'(TIMEOUT_CYCLES - 1)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    // No timer: an open packet waits for PACKET_LEN words or a flush.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state         <= EMPTY;
            pend_data     <= '0;
            word_cnt      <= '0;
            flush_req     <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            unique case (state)
                EMPTY: if (ev_fire) state <= HOLD;
                HOLD:  if (launch && !ev_fire) state <= EMPTY;
                default: state <= EMPTY;
            endcase

            if (ev_fire) begin
                pend_data <= ev_data;
            end

            // The held word leaves only when its tlast value is known.
            if (launch) begin
                m_axis_tdata  <= pend_data;
                m_axis_tlast  <= close;
                m_axis_tvalid <= 1'b1;
                word_cnt      <= close ? '0 : word_cnt + 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            if (launch) begin
                flush_req <= 1'b0;
            end else if (flush && pend_valid) begin
                flush_req <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_event_packetizer.sv
// Bench for axis_event_packetizer: packet-level scoreboard plus directed
// timing pins for length, timeout, flush, backpressure and reset.
module tb_axis_event_packetizer;

    localparam int W  = 64;
    localparam int PL = 4;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] ev_data = '0;
    logic         ev_valid = 1'b0;
    logic         ev_ready;
    logic         flush = 1'b0;
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tlast;
    logic         tready = 1'b1;
    logic         busy;

    axis_event_packetizer #(
        .AXIS_BUS_WIDTH(W),
        .PACKET_LEN(PL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .m_axi_aclk(clk),
        .m_axi_aresetn(rst_n),
        .ev_data(ev_data),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .flush(flush),
        .m_axis_tdata(tdata),
        .m_axis_tvalid(tvalid),
        .m_axis_tlast(tlast),
        .m_axis_tready(tready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } ent_t;

    ent_t         exp_q[$];
    logic [W-1:0] out_d[$];
    logic         out_l[$];
    int           out_c[$];
    int           acc_c[$];
    int           checks = 0;
    int           errors = 0;
    int           n_acc = 0;
    int           n_out = 0;
    logic         held_v = 1'b0;
    logic [W-1:0] held_d = '0;
    int           held_age = 0;
    int           next_idx = 0;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic close_held();
        ent_t e;
        e.d = held_d;
        e.l = 1'b1;
        exp_q.push_back(e);
        held_v   = 1'b0;
        next_idx = 0;
    endtask

    // Packet model: every accepted word gets an index; a word is last at
    // index PL-1, or when a flush/timeout closes the still-open newest word.
    task automatic mon();
        logic         prev_stall = 1'b0;
        logic [W-1:0] prev_d = '0;
        logic         prev_l = 1'b0;
        ent_t         e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                held_v     = 1'b0;
                next_idx   = 0;
                n_acc      = 0;
                n_out      = 0;
                prev_stall = 1'b0;
            end else begin
                check("busy", W'(busy), W'(n_acc != n_out));
                if (prev_stall) begin
                    check("stall_valid", W'(tvalid), W'(1));
                    check("stall_data", tdata, prev_d);
                    check("stall_last", W'(tlast), W'(prev_l));
                end
                if (tvalid && tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out got %0h want none", tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", tdata, e.d);
                        check("out_last", W'(tlast), W'(e.l));
                    end
                    n_out++;
                    out_d.push_back(tdata);
                    out_l.push_back(tlast);
                    out_c.push_back(cyc);
                end
                prev_stall = tvalid && !tready;
                prev_d     = tdata;
                prev_l     = tlast;
                if (held_v && flush) close_held();
`ifdef AXIS_PKT_TIMEOUT_EN
                if (held_v && held_age >= TO) close_held();
`endif
                if (ev_valid && ev_ready) begin
                    if (held_v) begin
                        e.d = held_d;
                        e.l = 1'b0;
                        exp_q.push_back(e);
                    end
                    n_acc++;
                    acc_c.push_back(cyc);
                    if (next_idx == PL - 1) begin
                        e.d = ev_data;
                        e.l = 1'b1;
                        exp_q.push_back(e);
                        held_v   = 1'b0;
                        next_idx = 0;
                    end else begin
                        held_v   = 1'b1;
                        held_d   = ev_data;
                        held_age = 0;
                        next_idx++;
                    end
                end else if (held_v) begin
                    held_age++;
                end
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] d);
        logic ok = 1'b0;
        ev_data  = d;
        ev_valid = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = ev_ready;
            @(posedge clk);
            #1;
        end
        ev_valid = 1'b0;
        check("send_accept", W'(ok), W'(1));
    endtask

    task automatic pulse_flush(output int f);
        flush = 1'b1;
        f     = cyc;
        tick(1);
        flush = 1'b0;
    endtask

    task automatic wait_outs(input string name, input int n, input int lim);
        for (int i = 0; i < lim && out_d.size() < n; i++) tick(1);
        check(name, W'(out_d.size() >= n), W'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int b;
        int a;
        int f;
        int f2;
        logic [3:0] lp;
        fork
            mon();
        join_none

        #2;
        check("rst_tvalid", W'(tvalid), W'(0));
        check("rst_tlast", W'(tlast), W'(0));
        check("rst_tdata", tdata, W'(0));
        check("rst_busy", W'(busy), W'(0));
        tick(3);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ev_ready", W'(ev_ready), W'(1));
        @(posedge clk);
        #1;

        // Two full packets at line rate
        b = out_d.size();
        a = acc_c.size();
        for (int i = 0; i < 8; i++) send(W'(i));
        wait_outs("t1_wait", b + 8, 40);
        if (out_d.size() >= b + 8) begin
            for (int k = 0; k < 8; k++) begin
                check("t1_data", out_d[b+k], W'(k));
                check("t1_last", W'(out_l[b+k]), W'(k == 3 || k == 7));
                if (k > 0) check("t1_gap", W'(out_c[b+k] - out_c[b+k-1]), W'(1));
            end
            check("t1_first_lat", W'(out_c[b] - acc_c[a]), W'(2));
            check("t1_final_lat", W'(out_c[b+3] - acc_c[a+3]), W'(2));
        end

        // Idle after a partial packet
        b = out_d.size();
        a = acc_c.size();
        send(W'('hA0));
        send(W'('hA1));
        send(W'('hA2));
`ifdef AXIS_PKT_TIMEOUT_EN
        wait_outs("t2_wait", b + 3, 40);
        if (out_d.size() >= b + 3) begin
            check("t2_a2_lat", W'(out_c[b+2] - acc_c[a+2]), W'(17));
            check("t2_a2_last", W'(out_l[b+2]), W'(1));
            check("t2_a1_last", W'(out_l[b+1]), W'(0));
        end
`else
        tick(40);
        check("t2_held", W'(out_d.size()), W'(b + 2));
        pulse_flush(f);
        wait_outs("t2_wait", b + 3, 10);
        if (out_d.size() >= b + 3) begin
            check("t2_flush_lat", W'(out_c[b+2] - f), W'(1));
            check("t2_a2_last", W'(out_l[b+2]), W'(1));
        end
`endif

        // Backpressure mid-stream
        b = out_d.size();
        a = acc_c.size();
        fork
            begin
                for (int i = 0; i < 10; i++) send(W'('hB0 + i));
            end
            begin
                for (int i = 0; i < 40 && acc_c.size() < a + 3; i++) tick(1);
                tready = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check("t3_ev_ready", W'(ev_ready), W'(0));
                    @(posedge clk);
                    #1;
                end
                tready = 1'b1;
            end
        join
        pulse_flush(f);
        wait_outs("t3_wait", b + 10, 40);
        if (out_d.size() >= b + 10) begin
            for (int k = 0; k < 10; k++) begin
                check("t3_data", out_d[b+k], W'('hB0 + k));
                check("t3_last", W'(out_l[b+k]), W'(k == 3 || k == 7 || k == 9));
            end
        end

        // Flush with two words pending, then flush while empty
        b = out_d.size();
        send(W'('hC0));
        send(W'('hC1));
        pulse_flush(f);
        wait_outs("t4_wait", b + 2, 10);
        if (out_d.size() >= b + 2) begin
            check("t4_flush_lat", W'(out_c[b+1] - f), W'(1));
            check("t4_c1_last", W'(out_l[b+1]), W'(1));
            check("t4_c1_data", out_d[b+1], W'('hC1));
            check("t4_c0_last", W'(out_l[b]), W'(0));
        end
        tick(3);
        pulse_flush(f2);
        tick(5);
        check("t4_empty_flush", W'(out_d.size()), W'(b + 2));
        check("t4_idle_busy", W'(busy), W'(0));
        for (int i = 0; i < 4; i++) send(W'('hD0 + i));
        wait_outs("t4_d_wait", b + 6, 20);
        if (out_d.size() >= b + 6) begin
            for (int k = 0; k < 4; k++)
                check("t4_d_last", W'(out_l[b+2+k]), W'(k == 3));
        end

        // Timeout expiring in the same cycle as a new word
        b = out_d.size();
        send(W'('hE0));
        tick(TO - 1);
        for (int i = 1; i < 5; i++) send(W'('hE0 + i));
        pulse_flush(f);
        wait_outs("t5_wait", b + 5, 60);
`ifdef AXIS_PKT_TIMEOUT_EN
        lp = 4'b0001;
`else
        lp = 4'b1000;
`endif
        if (out_d.size() >= b + 5) begin
            for (int k = 0; k < 4; k++)
                check("t5_last", W'(out_l[b+k]), W'(lp[k]));
            check("t5_e4_last", W'(out_l[b+4]), W'(1));
            check("t5_e4_data", out_d[b+4], W'('hE4));
        end

        // Asynchronous reset with a word on the output
        tready = 1'b0;
        send(W'('hF0));
        send(W'('hF1));
        check("t6_pre_tvalid", W'(tvalid), W'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_tvalid", W'(tvalid), W'(0));
        check("t6_rst_busy", W'(busy), W'(0));
        check("t6_rst_tdata", tdata, W'(0));
        tick(2);
        rst_n  = 1'b1;
        tready = 1'b1;
        tick(1);
        b = out_d.size();
        for (int i = 0; i < 4; i++) send(W'('h60 + i));
        wait_outs("t6_wait", b + 4, 20);
        if (out_d.size() >= b + 4) begin
            for (int k = 0; k < 4; k++) begin
                check("t6_data", out_d[b+k], W'('h60 + k));
                check("t6_last", W'(out_l[b+k]), W'(k == 3));
            end
        end

        tick(5);
        check("end_queue", W'(exp_q.size()), W'(0));
        check("end_held", W'(held_v), W'(0));
        check("end_count", W'(n_out), W'(n_acc));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_event_packetizer.md
# axis_event_packetizer

Frames a continuous stream of sensor event words into AXI-Stream packets with `tlast`. A packet closes after PACKET_LEN words, after an input idle timeout, or on an explicit flush. The block is the transmitter that feeds the `tlast`-aware AXIS FIFO on the event-readout path toward DMA. It holds back the most recent word so that `tlast` can be attached to it retroactively when a packet has to close early.

## Interface
Parameters:
- AXIS_BUS_WIDTH, 64, width of event word and `m_axis_tdata`.
- PACKET_LEN, 16, maximum words per packet; must be ≥ 2.
- TIMEOUT_CYCLES, 256, number of input-idle cycles before an open packet closes; must be ≥ 2.

Ports:
- m_axi_aclk  in  1  single clock, rising edge.
- m_axi_aresetn  in  1  asynchronous, active-low reset.
- ev_data  in  AXIS_BUS_WIDTH  event word.
- ev_valid  in  1  event word valid.
- ev_ready  out  1  event word accepted when `ev_valid & ev_ready`.
- flush  in  1  pulse; closes the open packet.
- m_axis_tdata  out  AXIS_BUS_WIDTH  output word.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  final word of packet.
- m_axis_tready  in  1  downstream ready.
- busy  out  1  `pend_valid | m_axis_tvalid`.

## Operation
Registers:
- `pend_data/pend_valid`: held word.
- Output register driving `m_axis_*`.
- `word_cnt`: 0..PACKET_LEN-1, index of the pend word within its packet.
- `idle_cnt`: saturating.
- `flush_req`: sticky.

Definitions:
- `out_free = !m_axis_tvalid | m_axis_tready`.
- `ev_ready = !pend_valid | out_free`.
- `ev_fire = ev_valid & ev_ready`.
- `close = (word_cnt == PACKET_LEN-1) | timeout_hit | flush_req | flush`.
- `timeout_hit = pend_valid & (idle_cnt >= TIMEOUT_CYCLES-1)`.
- `launch = pend_valid & out_free & (ev_fire | close)`.

FSM (encoded by `pend_valid`):
- EMPTY:
  - `ev_fire` → HOLD.
- HOLD:
  - `launch & !ev_fire` → EMPTY.
  - `launch & ev_fire` → HOLD (new word replaces the pend word the same cycle).
  - otherwise stay in HOLD.

On launch:
- Output register ← pend word, `tlast = close`.
- `word_cnt` ← 0 if close, else `word_cnt+1`.

`idle_cnt`:
- Cleared on `ev_fire` or launch-with-close.
- Otherwise increments while `pend_valid`, saturating at TIMEOUT_CYCLES-1.

`flush_req`:
- Set by `flush` while `pend_valid` and no launch occurs that cycle.
- Cleared on launch.
- `flush` while EMPTY is ignored.

Invariants:
- EMPTY implies no open packet, so `word_cnt == 0`.
- A non-final word launches only together with an `ev_fire` that refills pend.

Simultaneous events:
- `close` and `ev_fire` in the same cycle: the held word leaves with `tlast=1`, and the new word becomes word 0 of the next packet.

Output register:
- Loads only on launch.
- `m_axis_tvalid` clears on `m_axis_tready` when no launch occurs.
- `tdata/tlast` stay stable while `tvalid & !tready`.

Data guarantees:
- No word dropped, duplicated or reordered.

## Timing
- Reset (asynchronous, immediate): `m_axis_tvalid=0`, `m_axis_tlast=0`, `m_axis_tdata=0`, `busy=0`, `pend_valid=0`, `word_cnt=0`, `idle_cnt=0`, `flush_req=0`.
  - `ev_ready=1` from the first cycle after deassertion.
  - A partial packet in flight at reset is discarded.
- Throughput: with `m_axis_tready=1`, the block accepts and emits one word per cycle, including back-to-back packets.
- Packet-final word accepted in cycle N: `m_axis_tvalid` with `tlast=1` is visible in cycle N+2 when the output is free.
- Non-final word accepted in cycle N: it appears one cycle after the next `ev_fire`.
- Timeout: last word accepted in cycle N with no further input appears with `tlast=1` in cycle N+TIMEOUT_CYCLES+1.
- Flush: `flush` in cycle F with the output free → `tlast` word visible in cycle F+1.
- Backpressure: `ev_ready` falls in the same cycle that pend is full and `!out_free` (combinational).

## Configuration
- `AXIS_PKT_TIMEOUT_EN` defined: idle timeout is active as described.
- `AXIS_PKT_TIMEOUT_EN` undefined:
  - `idle_cnt` is not built and `timeout_hit` is 0.
  - Packets close only at PACKET_LEN or on `flush`.
  - A partial packet may be held indefinitely.
  - TIMEOUT_CYCLES is ignored.

## Test plan
- PACKET_LEN=4, 8 consecutive words 0..7, tready=1 → two packets. `tlast` is 1 only on words 3 and 7. Data in order. No bubbles after the first output.
- PACKET_LEN=16, TIMEOUT_CYCLES=16, words 0xA0..0xA2 then idle → 0xA0 and 0xA1 are emitted with `tlast=0`. 0xA2 is emitted with `tlast=1` exactly 17 cycles after its acceptance. With `AXIS_PKT_TIMEOUT_EN` undefined, 0xA2 is never emitted.
- Continuous stream with tready held low for 10 cycles mid-packet → `ev_ready=0` after 2 words are buffered. `tdata/tlast` stable throughout. All words received once, in order.
- 2 words pending, `flush` pulse → the 2nd word is emitted with `tlast=1` within 1 cycle. A 2nd `flush` while EMPTY produces no output. The next word starts with `word_cnt=0`.
- Timeout hit coincides with a new `ev_valid` → the held word gets `tlast=1`, and the new word is the first of the next packet (next `tlast` after PACKET_LEN further words).
- `m_axi_aresetn` asserted mid-packet with `tvalid=1` → `tvalid` and `busy` go 0 without waiting for a clock edge. After release, 4 words with PACKET_LEN=4 produce `tlast` on the 4th.
